// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data-memory arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic                  core_gnt_o;
  logic                  core_stall_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;

  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [ADDR_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0] dbg_wdata_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_WIDTH-1:0] dbg_rdata_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_wen_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_wen_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_wen_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core MEM stage and the debug port,
// with core priority, a starvation-forced debug grant and 1-cycle read data routing.
//
// state       | meaning
// CORE_PRIO   | core wins any contended cycle; dbg only when core is idle
// DBG_PRIO    | dbg starved MAX_WAIT cycles; wins the next access, then back to CORE_PRIO
// RESP_NONE   | no read in flight
// RESP_CORE   | core load granted last cycle; mem_rdata_i belongs to core
// RESP_DBG    | dbg load granted last cycle; mem_rdata_i belongs to dbg
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input logic              clk,
  input logic              rst,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic {CORE_PRIO, DBG_PRIO} arb_t;
  typedef enum logic [1:0] {RESP_NONE, RESP_CORE, RESP_DBG} resp_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  arb_t       arb_q, arb_d;
  resp_t      resp_q, resp_d;
  logic [7:0] wait_q, wait_d;
  logic       core_gnt, dbg_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_q  <= CORE_PRIO;
      resp_q <= RESP_NONE;
      wait_q <= '0;
    end else begin
      arb_q  <= arb_d;
      resp_q <= resp_d;
      wait_q <= wait_d;
    end
  end

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    wait_d   = '0;
    arb_d    = arb_q;
    resp_d   = RESP_NONE;

    // Grants are held off entirely while reset is asserted.
    if (rst) begin
      if (arb_q == DBG_PRIO && bus.dbg_req_i)
        dbg_gnt = 1'b1;
      else if (bus.core_req_i)
        core_gnt = 1'b1;
      else if (bus.dbg_req_i)
        dbg_gnt = 1'b1;
    end

    if (bus.dbg_req_i && !dbg_gnt)
      wait_d = (wait_q >= MAX_WAIT_C) ? wait_q : wait_q + 8'd1;

    case (arb_q)
      CORE_PRIO: if (wait_d == MAX_WAIT_C) arb_d = DBG_PRIO;
      DBG_PRIO:  arb_d = CORE_PRIO;  // one forced access, or dbg withdrew
      default:   arb_d = CORE_PRIO;
    endcase

    if (core_gnt && !bus.core_we_i)
      resp_d = RESP_CORE;
    else if (dbg_gnt && !bus.dbg_we_i)
      resp_d = RESP_DBG;
  end

  assign bus.core_gnt_o   = core_gnt;
  assign bus.dbg_gnt_o    = dbg_gnt;
  assign bus.core_stall_o = rst && bus.core_req_i && !core_gnt;

  assign bus.mem_addr_o  = dbg_gnt ? bus.dbg_addr_i  : bus.core_addr_i;
  assign bus.mem_wdata_o = dbg_gnt ? bus.dbg_wdata_i : bus.core_wdata_i;
  assign bus.mem_wen_o   = (core_gnt && bus.core_we_i) || (dbg_gnt && bus.dbg_we_i);

  assign bus.core_rvalid_o = (resp_q == RESP_CORE);
  assign bus.dbg_rvalid_o  = (resp_q == RESP_DBG);
  assign bus.core_rdata_o  = (resp_q == RESP_CORE) ? bus.mem_rdata_i : '0;
  assign bus.dbg_rdata_o   = (resp_q == RESP_DBG)  ? bus.mem_rdata_i : '0;

endmodule
